// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and sizing helpers for the convolution blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    function automatic int kernel_area(input int kernel_width);
        return kernel_width * kernel_width;
    endfunction

    function automatic int bank_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    localparam int KERNEL_WIDTH_DEFAULT = 3;
    localparam int WEIGHT_WIDTH_DEFAULT = 2;

    // Packed weights for the default kernel, index r*KernelWidth+c
    typedef logic [kernel_area(KERNEL_WIDTH_DEFAULT)*WEIGHT_WIDTH_DEFAULT-1:0] weight_vec_t;

endpackage
`default_nettype wire

// File: rtl/weight_bank_rf.sv
`default_nettype none
// ============================================================================
// Module      : weight_bank_rf
// Description : NumBanks x WordW register file, one write port, one async read.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_bank_rf #(
    parameter int NumBanks = 4,
    parameter int WordW    = 18,
    parameter int AddrW    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [WordW-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [WordW-1:0] rdata_o
);

    logic [NumBanks*WordW-1:0] bank_flat;

    generate
        for (genvar b = 0; b < NumBanks; b++) begin : g_bank
            logic [WordW-1:0] bank_q;
            logic [WordW-1:0] bank_d;

            always_comb begin
                bank_d = bank_q;
                if (we_i && (waddr_i == AddrW'(b))) begin
                    bank_d = wdata_i;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    bank_q <= '0;
                end else begin
                    bank_q <= bank_d;
                end
            end

            assign bank_flat[b*WordW +: WordW] = bank_q;
        end
    endgenerate

    // Out-of-range addresses (non power-of-two bank counts) read as zero
    always_comb begin
        rdata_o = '0;
        for (int b = 0; b < NumBanks; b++) begin
            if (raddr_i == AddrW'(b)) begin
                rdata_o = bank_flat[b*WordW +: WordW];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_frame_sequencer
// Description : Frame gating and between-frame weight bank swapping for conv2d.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_frame_sequencer
    import conv_pkg::*;
#(
    parameter int LineWidthPx = 160,
    parameter int LineCountPx = 120,
    parameter int WidthIn     = 2,
    parameter int KernelWidth = 3,
    parameter int WeightWidth = 2,
    parameter int NumBanks    = 4,
    localparam int KernelArea = kernel_area(KernelWidth),
    localparam int BankW      = bank_w(NumBanks)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              start_i,
    input  logic                              continuous_i,
    input  logic                              sel_valid_i,
    input  logic [BankW-1:0]                  sel_bank_i,
    input  logic                              cfg_valid_i,
    output logic                              cfg_ready_o,
    input  logic [BankW-1:0]                  cfg_bank_i,
    input  logic [KernelArea*WeightWidth-1:0] cfg_weights_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic [WidthIn-1:0]                data_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [WidthIn-1:0]                data_o,
    input  logic                              conv_valid_i,
    output logic [KernelArea*WeightWidth-1:0] weights_o,
    output logic [BankW-1:0]                  active_bank_o,
    output logic                              frame_done_o,
    output logic                              busy_o
);

    localparam int WW = KernelArea * WeightWidth;
    localparam int XW = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
    localparam int YW = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;

    logic [1:0]       state_q, state_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             cont_q, cont_d;
    logic [BankW-1:0] pending_q, pending_d;
    logic [BankW-1:0] active_bank_q, active_bank_d;
    logic [WW-1:0]    weights_q, weights_d;
    logic             frame_done_q, frame_done_d;

    logic             run;
    logic             busy;
    logic             fire;
    logic             x_last;
    logic             y_last;
    logic             last_px;
    logic             swap_en;
    logic             cfg_ready;
    logic             cfg_fire;
    logic [WW-1:0]    rd_weights;

    always_comb begin
        run     = (state_q == S_RUN);
        busy    = (state_q != S_IDLE);
        fire    = valid_i & ready_i & run;
        x_last  = (x_q == XW'(LineWidthPx - 1));
        y_last  = (y_q == YW'(LineCountPx - 1));
        last_px = fire & x_last & y_last;
        // Gated by reset so cfg_ready_o reads 1 while reset is held
        swap_en = ~rst_i & (((state_q == S_IDLE) & start_i) |
                            ((state_q == S_DRAIN) & ~conv_valid_i));
        cfg_ready = ~swap_en & ~(busy & (cfg_bank_i == active_bank_q));
        cfg_fire  = cfg_valid_i & cfg_ready;
    end

    always_comb begin
        state_d = state_q;
        cont_d  = cont_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (last_px) begin
                    state_d = S_DRAIN;
                    cont_d  = continuous_i;
                end
            end
            S_DRAIN: begin
                if (!conv_valid_i) begin
                    state_d = cont_q ? S_RUN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters restart on every swap to stay in lockstep with conv2d
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (swap_en) begin
            x_d = '0;
            y_d = '0;
        end else if (fire) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : (y_q + YW'(1));
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_comb begin
        pending_d     = sel_valid_i ? sel_bank_i : pending_q;
        active_bank_d = swap_en ? pending_q : active_bank_q;
        weights_d     = swap_en ? rd_weights : weights_q;
        frame_done_d  = (state_q == S_DRAIN) & ~conv_valid_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            cont_q        <= 1'b0;
            pending_q     <= '0;
            active_bank_q <= '0;
            weights_q     <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            cont_q        <= cont_d;
            pending_q     <= pending_d;
            active_bank_q <= active_bank_d;
            weights_q     <= weights_d;
            frame_done_q  <= frame_done_d;
        end
    end

    weight_bank_rf #(
        .NumBanks (NumBanks),
        .WordW    (WW),
        .AddrW    (BankW)
    ) u_bank_rf (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .we_i     (cfg_fire),
        .waddr_i  (cfg_bank_i),
        .wdata_i  (cfg_weights_i),
        .raddr_i  (pending_q),
        .rdata_o  (rd_weights)
    );

    assign valid_o       = valid_i & run;
    assign ready_o       = ready_i & run;
    assign data_o        = data_i;
    assign cfg_ready_o   = cfg_ready;
    assign weights_o     = weights_q;
    assign active_bank_o = active_bank_q;
    assign frame_done_o  = frame_done_q;
    assign busy_o        = busy;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_frame_sequencer
// Description : Vector table, directed corner cases and random run vs. model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_frame_sequencer;

    localparam int LW    = 4;
    localparam int LC    = 3;
    localparam int FRAME = LW * LC;
    localparam int NB    = 2;
    localparam int VW    = 18;
    localparam logic [VW-1:0] W_POS = 18'h15555;  // nine +1 weights
    localparam logic [VW-1:0] W_NEG = 18'h3FFFF;  // nine -1 weights

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i, continuous_i, sel_valid_i, cfg_valid_i;
    logic [0:0]    sel_bank_i, cfg_bank_i;
    logic [VW-1:0] cfg_weights_i;
    logic          valid_i, ready_i, conv_valid_i;
    logic [1:0]    data_i;
    logic          cfg_ready_o, ready_o, valid_o, frame_done_o, busy_o;
    logic [1:0]    data_o;
    logic [VW-1:0] weights_o;
    logic [0:0]    active_bank_o;

    always #5 clk = ~clk;

    conv_frame_sequencer #(
        .LineWidthPx (LW), .LineCountPx (LC), .WidthIn (2),
        .KernelWidth (3), .WeightWidth (2), .NumBanks (NB)
    ) dut (
        .clk_i (clk), .rst_i (rst_i), .start_i (start_i), .continuous_i (continuous_i),
        .sel_valid_i (sel_valid_i), .sel_bank_i (sel_bank_i),
        .cfg_valid_i (cfg_valid_i), .cfg_ready_o (cfg_ready_o), .cfg_bank_i (cfg_bank_i),
        .cfg_weights_i (cfg_weights_i), .valid_i (valid_i), .ready_o (ready_o), .data_i (data_i),
        .valid_o (valid_o), .ready_i (ready_i), .data_o (data_o), .conv_valid_i (conv_valid_i),
        .weights_o (weights_o), .active_bank_o (active_bank_o),
        .frame_done_o (frame_done_o), .busy_o (busy_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum {P_IDLE, P_RUN, P_DRAIN} phase_t;
    phase_t        m_phase;
    int            m_pix;
    bit            m_chain;
    logic [VW-1:0] m_bank [NB];
    logic          m_pending, m_active, m_done;
    logic [VW-1:0] m_weights;
    int            dut_fires;
    logic          pre_cfg_ready;

    function automatic void model_reset();
        m_phase = P_IDLE; m_pix = 0; m_chain = 0;
        for (int b = 0; b < NB; b++) m_bank[b] = '0;
        m_pending = 0; m_active = 0; m_done = 0; m_weights = '0;
    endfunction

    // Called at posedge+1 with inputs set; returns at the next posedge+1
    task automatic step();
        bit run, swap, cfg_ok, fire;
        #3;
        run    = (m_phase == P_RUN);
        swap   = (m_phase == P_IDLE && start_i) || (m_phase == P_DRAIN && !conv_valid_i);
        cfg_ok = !swap && !(m_phase != P_IDLE && cfg_bank_i == m_active);
        fire   = valid_i && ready_i && run;
        chk("ready_o", ready_o, ready_i & run);
        chk("valid_o", valid_o, valid_i & run);
        chk("data_o", data_o, data_i);
        chk("cfg_ready_o", cfg_ready_o, cfg_ok);
        pre_cfg_ready = cfg_ready_o;
        if (valid_o && ready_o) dut_fires++;
        @(posedge clk);
        m_done = (m_phase == P_DRAIN && !conv_valid_i);
        if (swap) begin
            m_weights = m_bank[m_pending];
            m_active  = m_pending;
        end
        if (cfg_valid_i && cfg_ok) m_bank[cfg_bank_i] = cfg_weights_i;
        if (sel_valid_i) m_pending = sel_bank_i;
        case (m_phase)
            P_IDLE:  if (start_i) begin m_phase = P_RUN; m_pix = 0; end
            P_RUN:   if (fire) begin
                         m_pix++;
                         if (m_pix == FRAME) begin m_phase = P_DRAIN; m_chain = continuous_i; end
                     end
            P_DRAIN: if (!conv_valid_i) begin m_phase = m_chain ? P_RUN : P_IDLE; m_pix = 0; end
            default: m_phase = P_IDLE;
        endcase
        #1;
        chk("weights_o", weights_o, m_weights);
        chk("active_bank_o", active_bank_o, m_active);
        chk("frame_done_o", frame_done_o, m_done);
        chk("busy_o", busy_o, m_phase != P_IDLE);
    endtask

    task automatic clear_inputs();
        start_i = 0; continuous_i = 0; sel_valid_i = 0; sel_bank_i = 0;
        cfg_valid_i = 0; cfg_bank_i = 0; cfg_weights_i = '0;
        valid_i = 0; ready_i = 0; conv_valid_i = 0; data_i = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic cfg_write(input logic b, input logic [VW-1:0] w);
        cfg_valid_i = 1; cfg_bank_i = b; cfg_weights_i = w;
        step();
        cfg_valid_i = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic start, valid, conv, cfg_v, cfg_b;
        logic [VW-1:0] cfg_w;
        logic e_ready, e_cfg_ready, e_busy, e_done, e_bank;
        logic [VW-1:0] e_w;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(logic st, logic v, logic cv, logic cfv, logic cfb, logic [VW-1:0] cfw,
                                logic er, logic ecr, logic eb, logic ed, logic ebk, logic [VW-1:0] ew);
        vec_t t;
        t.start = st; t.valid = v; t.conv = cv; t.cfg_v = cfv; t.cfg_b = cfb; t.cfg_w = cfw;
        t.e_ready = er; t.e_cfg_ready = ecr; t.e_busy = eb; t.e_done = ed; t.e_bank = ebk; t.e_w = ew;
        return t;
    endfunction

    int  done_cnt, idle_seen, budget;
    logic want;

    initial begin
        tv.push_back(mk(0, 0, 0, 1, 0, W_POS, 0, 1, 0, 0, 0, '0));
        tv.push_back(mk(0, 0, 0, 1, 1, W_NEG, 0, 1, 0, 0, 0, '0));
        tv.push_back(mk(1, 0, 0, 0, 0, '0,    0, 0, 1, 0, 0, W_POS));
        for (int i = 0; i < FRAME; i++)
            tv.push_back(mk(0, 1, 0, 0, 0, '0, 1, 0, 1, 0, 0, W_POS));
        tv.push_back(mk(0, 1, 1, 0, 1, '0,    0, 1, 1, 0, 0, W_POS));
        tv.push_back(mk(0, 1, 0, 0, 0, '0,    0, 0, 0, 1, 0, W_POS));
        tv.push_back(mk(0, 0, 0, 0, 0, '0,    0, 1, 0, 0, 0, W_POS));

        // Reset with hostile inputs held high
        rst_i = 1'b1;
        clear_inputs();
        start_i = 1; valid_i = 1; ready_i = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy_o", busy_o, 0);
        chk("rst valid_o", valid_o, 0);
        chk("rst ready_o", ready_o, 0);
        chk("rst cfg_ready_o", cfg_ready_o, 1);
        chk("rst weights_o", weights_o, 0);
        chk("rst active_bank_o", active_bank_o, 0);
        chk("rst frame_done_o", frame_done_o, 0);
        clear_inputs();
        rst_i = 1'b0;

        foreach (tv[i]) begin
            start_i = tv[i].start; valid_i = tv[i].valid; ready_i = 1; conv_valid_i = tv[i].conv;
            cfg_valid_i = tv[i].cfg_v; cfg_bank_i = tv[i].cfg_b; cfg_weights_i = tv[i].cfg_w;
            #3;
            chk($sformatf("tv%0d ready_o", i), ready_o, tv[i].e_ready);
            chk($sformatf("tv%0d cfg_ready_o", i), cfg_ready_o, tv[i].e_cfg_ready);
            @(posedge clk);
            #1;
            chk($sformatf("tv%0d busy_o", i), busy_o, tv[i].e_busy);
            chk($sformatf("tv%0d frame_done_o", i), frame_done_o, tv[i].e_done);
            chk($sformatf("tv%0d active_bank_o", i), active_bank_o, tv[i].e_bank);
            chk($sformatf("tv%0d weights_o", i), weights_o, tv[i].e_w);
        end

        // Drain hold: bank1 selected mid-frame, conv2d still busy for 5 cycles
        do_reset();
        cfg_write(0, W_POS);
        cfg_write(1, W_NEG);
        start_i = 1; step(); start_i = 0;
        valid_i = 1; ready_i = 1;
        for (int i = 0; i < FRAME; i++) begin
            sel_valid_i = (i == 5); sel_bank_i = 1;
            data_i = 2'($urandom);
            step();
        end
        sel_valid_i = 0;
        conv_valid_i = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("drain hold weights_o", weights_o, W_POS);
        end
        conv_valid_i = 0;
        step();
        chk("drain exit weights_o", weights_o, W_NEG);
        chk("drain exit active_bank_o", active_bank_o, 1);
        chk("drain exit frame_done_o", frame_done_o, 1);

        // Write protection on the active bank
        valid_i = 0;
        sel_valid_i = 1; sel_bank_i = 0; step(); sel_valid_i = 0;
        start_i = 1; step(); start_i = 0;
        cfg_valid_i = 1; cfg_bank_i = 0; cfg_weights_i = W_NEG;
        valid_i = 1;
        budget = 0;
        while (busy_o && budget < 40) begin
            step();
            chk("protect cfg_ready_o", pre_cfg_ready, 0);
            budget++;
        end
        chk("protect reached idle", busy_o, 0);
        step();
        chk("idle cfg accepted", pre_cfg_ready, 1);
        cfg_valid_i = 0;
        start_i = 1; step(); start_i = 0;
        cfg_valid_i = 1; cfg_bank_i = 1; cfg_weights_i = W_POS;
        step();
        chk("run other bank accepted", pre_cfg_ready, 1);
        cfg_valid_i = 0;
        while (busy_o && budget < 80) begin step(); budget++; end

        // Continuous mode over three frames, alternating banks
        do_reset();
        cfg_write(0, W_POS);
        cfg_write(1, W_NEG);
        start_i = 1; continuous_i = 1; step(); start_i = 0;
        valid_i = 1; ready_i = 1;
        want = 1; sel_valid_i = 1; sel_bank_i = want;
        done_cnt = 0; idle_seen = 0; budget = 0;
        while (done_cnt < 3 && budget < 300) begin
            conv_valid_i = 1'($urandom);
            data_i = 2'($urandom);
            step();
            sel_valid_i = 0;
            budget++;
            if (frame_done_o) begin
                done_cnt++;
                chk("continuous active_bank_o", active_bank_o, want);
                want = ~want; sel_valid_i = 1; sel_bank_i = want;
                if (done_cnt == 2) continuous_i = 0;
            end else if (!busy_o) begin
                idle_seen++;
            end
        end
        sel_valid_i = 0;
        chk("continuous done pulses", done_cnt, 3);
        chk("continuous idle visits", idle_seen, 0);
        chk("continuous final idle", busy_o, 0);

        // Asynchronous reset mid-frame
        do_reset();
        start_i = 1; step(); start_i = 0;
        valid_i = 1; ready_i = 1;
        repeat (7) step();
        rst_i = 1'b1;
        #1;
        chk("async rst busy_o", busy_o, 0);
        chk("async rst valid_o", valid_o, 0);
        chk("async rst ready_o", ready_o, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        start_i = 1; step(); start_i = 0;
        dut_fires = 0; budget = 0;
        while (!frame_done_o && budget < 50) begin
            ready_i = 1'($urandom);
            step();
            budget++;
        end
        chk("post-reset frame_done seen", frame_done_o, 1);
        chk("post-reset full frame fires", dut_fires, FRAME);

        // Random traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            start_i       = ($urandom_range(0, 9) < 2);
            continuous_i  = 1'($urandom);
            valid_i       = ($urandom_range(0, 9) < 7);
            ready_i       = 1'($urandom);
            conv_valid_i  = 1'($urandom);
            sel_valid_i   = ($urandom_range(0, 9) == 0);
            sel_bank_i    = 1'($urandom);
            cfg_valid_i   = ($urandom_range(0, 9) < 2);
            cfg_bank_i    = 1'($urandom);
            cfg_weights_i = VW'($urandom);
            data_i        = 2'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_frame_sequencer.md
# conv_frame_sequencer

Frame-level controller placed in front of `conv2d`. It owns a bank of `NumBanks` kernel weight sets and gates the pixel stream into the convolver one frame at a time. It counts pixels to locate frame boundaries and swaps the active weight set only between frames, after the convolver's last output has drained, so no output is ever computed with mixed weights.

## Interface
- `LineWidthPx`, 160, pixels per line; must match the downstream `conv2d`
- `LineCountPx`, 120, lines per frame
- `WidthIn`, 2, pixel width
- `KernelWidth`, 3, kernel side; `KernelArea = KernelWidth*KernelWidth`
- `WeightWidth`, 2, signed weight width
- `NumBanks`, 4, stored weight sets, ≥2; `BankW = $clog2(NumBanks)`
- `clk_i` in 1: the single clock
- `rst_i` in 1: reset, **asynchronous, active-high**
- `start_i` in 1: level-sampled request to begin a frame; acted on only in IDLE
- `continuous_i` in 1: sampled on the last pixel fire; 1 = chain the next frame without start_i
- `sel_valid_i` in 1: pulse; latches `sel_bank_i` as the pending bank
- `sel_bank_i` in BankW: bank for the next frame
- `cfg_valid_i` in 1 / `cfg_ready_o` out 1: weight-write handshake
- `cfg_bank_i` in BankW: bank to write
- `cfg_weights_i` in KernelArea*WeightWidth: packed weights, index `r*KernelWidth+c`
- `valid_i` in 1 / `ready_o` out 1 / `data_i` in WidthIn: upstream pixel stream
- `valid_o` out 1 / `ready_i` in 1 / `data_o` out WidthIn: pixel stream to `conv2d`
- `conv_valid_i` in 1: the `conv2d` `valid_o`, used for drain detection
- `weights_o` out KernelArea*WeightWidth: registered active weights to `conv2d` `weights_i`
- `active_bank_o` out BankW: bank currently driving `weights_o`
- `frame_done_o` out 1: one-cycle pulse, registered
- `busy_o` out 1: high when the state is not IDLE

## Operation
- FSM states:
  - IDLE: stream gated. When `start_i`=1, do a bank swap and go to RUN.
  - RUN: stream passes through. A fire on the last pixel goes to DRAIN.
  - DRAIN: stream gated. When `conv_valid_i`=0, do a bank swap. Then go to RUN if the latched `continuous_i` was 1, else IDLE.
- Stream pass-through (combinational):
  - `valid_o = valid_i & run`, `ready_o = ready_i & run`, `data_o = data_i`
  - `fire = valid_i & ready_i & run`
- Counters:
  - x/y counters advance on `fire` and wrap at `LineWidthPx-1` / `LineCountPx-1`.
  - They are cleared on every swap, so each frame starts at (0,0) in lockstep with `conv2d`'s counters.
  - The last pixel is `x==LineWidthPx-1 && y==LineCountPx-1`, qualified by `fire`.
- Bank swap (`swap_en`):
  - Loads `active_bank_r <= pending_r` and `weights_o <= bank[pending_r]`.
- Pending bank: `sel_valid_i` writes `pending_r <= sel_bank_i`.
- Config writes:
  - `cfg_ready_o = ~swap_en & ~(busy & cfg_bank_i==active_bank_r)`.
  - On a cfg fire, `bank[cfg_bank_i] <= cfg_weights_i`.
  - The active bank is write-protected while busy. All banks are writable in IDLE.
- `frame_done_o` pulses in the cycle after the swap that exits DRAIN.
- Reset (asynchronous): state IDLE, counters 0, all banks 0, `pending_r`=0, `active_bank_r`=0, `weights_o`=0, `frame_done_o`=0. Combinational outputs under reset: `busy_o`=0, `valid_o`=0, `ready_o`=0, `cfg_ready_o`=1.

## Timing
- Pixel path: zero latency, no buffering.
- IDLE→RUN: `start_i` seen at edge N → `weights_o` and `active_bank_o` update at N, and `ready_o` can be high from cycle N+1.
- Last pixel fire at edge N → DRAIN from N+1. `ready_o`=0 from N+1 until the state returns to RUN.
- DRAIN exit:
  - The swap occurs at the first edge where `conv_valid_i`=0 in DRAIN.
  - `frame_done_o` is high for exactly the following cycle.
  - In continuous mode, pixels are accepted again one cycle after the swap.
- Simultaneous events:
  - `sel_valid_i` in the swap cycle: the swap uses the old `pending_r`; the new value applies to the following frame.
  - `cfg_valid_i` in the swap cycle: stalled by `cfg_ready_o`=0.
  - `cfg` to the pending bank while RUN: allowed, and takes effect at the next swap.
  - `start_i` outside IDLE: ignored.
  - `ready_i` low mid-frame: counters hold.
- Reset mid-frame: returns to IDLE asynchronously. Any partial frame is discarded.
- Because `conv2d` uses a synchronous reset, the system top must reset both blocks together.

## Structure
- Shared package `conv_pkg`:
  - state enum `seq_state_e` {IDLE, RUN, DRAIN}
  - the `KernelArea` and `BankW` helper functions
  - a packed weight-vector typedef, also usable by `conv2d`
- One natural sub-module, `weight_bank_rf`:
  - NumBanks × KernelArea*WeightWidth register file
  - one write port, one asynchronous read port addressed by `pending_r`
  - resets to zero
- The FSM, counters and stream gating stay in the top module.

## Test plan
All scenarios use LineWidthPx=4, LineCountPx=3, NumBanks=2.
- Reset, then cfg bank0=all +1 and bank1=all −1, then `start_i` → `weights_o`=bank0 and `active_bank_o`=0. Stream 12 pixels → exactly 12 fires, then DRAIN, then a `frame_done_o` pulse and IDLE.
- Downstream backpressure: random `ready_i` at 50% → counters hold when stalled, the last-pixel detect lands on the 12th fire, and no pixel passes during DRAIN.
- Drain hold: `sel_bank_i`=1 mid-frame and `conv_valid_i` held high for 5 cycles after the last pixel → `weights_o` unchanged for those 5 cycles, then switches to bank1 one edge after `conv_valid_i` falls.
- Write protection: cfg to bank0 while RUN on bank0 → `cfg_ready_o`=0 until IDLE. The same write to bank1 is accepted in 1 cycle.
- Continuous mode: `continuous_i`=1 across 3 frames → three `frame_done_o` pulses, no IDLE visits, and each frame uses the pending bank selected during the previous frame.
- Asynchronous reset asserted after 7 pixels → `busy_o`=0 immediately; after release, the next `start_i` frame needs a full 12 pixels before `frame_done_o`.
